// File: rtl/mic_conditioner.sv
// Microphone conditioner: leaky-integrator DC removal, shift gain with saturation,
// and a hold-timed noise gate. Three-stage pipeline, one sample per cycle.
module mic_conditioner #(
  parameter int DC_SHIFT     = 10,
  parameter int HOLD_SAMPLES = 4800
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [23:0] sample_in,
  input  logic        valid_in,
  input  logic [3:0]  gain_in,
  input  logic [15:0] gate_thresh_in,
  output logic [15:0] sample_out,
  output logic        valid_out,
  output logic        gate_open_out
);

  localparam int AccW = 24 + DC_SHIFT + 1;
  localparam int CntW = $clog2(HOLD_SAMPLES + 1);

  localparam logic [0:0] StClosed = 1'b0;
  localparam logic [0:0] StOpen   = 1'b1;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [24:0]     c_q, c_d, c_new;
  logic                   v1_q, v1_d;

  logic [3:0]             gain_eff;
  logic signed [32:0]     wide;
  logic signed [24:0]     y_full;
  logic [15:0]            ysat_q, ysat_d;
  logic                   v2_q, v2_d;

  logic [16:0]            mag;
  logic                   loud;
  logic [0:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [15:0]            sample_out_q, sample_out_d;
  logic                   valid_out_q, valid_out_d;

  // Stage 1: the upper 25 bits of acc are exactly acc >>> DC_SHIFT.
  always_comb begin
    c_new = $signed({sample_in[23], sample_in}) - $signed(acc_q[AccW-1:DC_SHIFT]);
    c_d   = c_q;
    acc_d = acc_q;
    v1_d  = valid_in;
    if (valid_in) begin
      c_d   = c_new;
      acc_d = acc_q + $signed({{DC_SHIFT{c_new[24]}}, c_new});
    end
  end

  // Stage 2: gain shift at full width, then saturate to 16 bits.
  always_comb begin
    gain_eff = (gain_in > 4'd8) ? 4'd8 : gain_in;
    wide     = $signed({{8{c_q[24]}}, c_q}) <<< gain_eff;
    y_full   = 25'(wide >>> 8);
    ysat_d   = ysat_q;
    v2_d     = v1_q;
    if (v1_q) begin
      if (!y_full[24] && (|y_full[23:15])) begin
        ysat_d = 16'h7FFF;
      end else if (y_full[24] && !(&y_full[23:15])) begin
        ysat_d = 16'h8000;
      end else begin
        ysat_d = y_full[15:0];
      end
    end
  end

  // Stage 3: magnitude, threshold and gate FSM.
  always_comb begin
    mag          = ysat_q[15] ? (17'd0 - {1'b1, ysat_q}) : {1'b0, ysat_q};
    loud         = (mag >= {1'b0, gate_thresh_in});
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_out_d = sample_out_q;
    valid_out_d  = v2_q;
    if (v2_q) begin
      unique case (state_q)
        StClosed: begin
          if (loud) begin
            state_d      = StOpen;
            cnt_d        = CntW'(HOLD_SAMPLES);
            sample_out_d = ysat_q;
          end else begin
            sample_out_d = 16'd0;
          end
        end
        StOpen: begin
          sample_out_d = ysat_q;
          if (loud) begin
            cnt_d = CntW'(HOLD_SAMPLES);
          end else begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StClosed;
          end
        end
        default: state_d = StClosed;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q        <= '0;
      c_q          <= '0;
      v1_q         <= 1'b0;
      ysat_q       <= '0;
      v2_q         <= 1'b0;
      state_q      <= StClosed;
      cnt_q        <= '0;
      sample_out_q <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      c_q          <= c_d;
      v1_q         <= v1_d;
      ysat_q       <= ysat_d;
      v2_q         <= v2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_out_q <= sample_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign sample_out    = sample_out_q;
  assign valid_out     = valid_out_q;
  assign gate_open_out = (state_q == StOpen);

endmodule

// File: tb/tb_mic_conditioner.sv
// Scoreboard bench for mic_conditioner: two instances (DC_SHIFT 16 and 4, hold 4)
// share stimulus; a reference model fills per-instance queues, monitors compare.
module tb_mic_conditioner;

  localparam int Hold = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sample;
  logic        vin;
  logic [3:0]  gain;
  logic [15:0] thr;
  logic [15:0] out_a, out_b;
  logic        vout_a, vout_b, gate_a, gate_b;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mic_conditioner #(.DC_SHIFT(16), .HOLD_SAMPLES(Hold)) dut_a (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .valid_in(vin), .gain_in(gain),
    .gate_thresh_in(thr), .sample_out(out_a), .valid_out(vout_a), .gate_open_out(gate_a)
  );

  mic_conditioner #(.DC_SHIFT(4), .HOLD_SAMPLES(Hold)) dut_b (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .valid_in(vin), .gain_in(gain),
    .gate_thresh_in(thr), .sample_out(out_b), .valid_out(vout_b), .gate_open_out(gate_b)
  );

  typedef struct {
    logic [15:0] val;
    logic        gate;
    longint      cyc;
  } exp_t;

  exp_t   q_a[$], q_b[$];
  exp_t   ea, eb;
  longint acc_a, acc_b;
  bit     open_a, open_b;
  int     cnt_a, cnt_b;

  logic [15:0] cap_val[$];
  logic        cap_gate[$];
  longint      cap_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: DC tracker as exact integer arithmetic, then gain, clamp and gate rules.
  task automatic model_step(input int sh, inout longint acc, inout bit open, inout int cnt,
                            input logic [23:0] s, output logic [15:0] val, output logic gate);
    longint x, c, y, mag;
    int     g;
    x   = longint'($signed(s));
    c   = x - (acc >>> sh);
    acc = acc + c;
    g   = (gain > 4'd8) ? 8 : int'(gain);
    y   = (c * (longint'(1) << g)) >>> 8;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    mag = (y < 0) ? -y : y;
    if (!open) begin
      if (mag >= longint'(thr)) begin
        open = 1'b1;
        cnt  = Hold;
        val  = 16'(y);
      end else begin
        val = 16'd0;
      end
    end else begin
      val = 16'(y);
      if (mag >= longint'(thr)) cnt = Hold;
      else begin
        cnt--;
        if (cnt == 0) open = 1'b0;
      end
    end
    gate = open;
  endtask

  task automatic drive(input bit v, input logic [23:0] s);
    exp_t e;
    logic [15:0] val;
    logic gt;
    @(negedge clk);
    vin    = v;
    sample = s;
    if (v) begin
      e.cyc = cyc;
      model_step(16, acc_a, open_a, cnt_a, s, val, gt);
      e.val = val; e.gate = gt;
      q_a.push_back(e);
      model_step(4, acc_b, open_b, cnt_b, s, val, gt);
      e.val = val; e.gate = gt;
      q_b.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1'b1;
    vin = 1'b0;
    q_a.delete(); q_b.delete();
    acc_a = 0; acc_b = 0; open_a = 0; open_b = 0; cnt_a = 0; cnt_b = 0;
    repeat (n) @(negedge clk);
    check("rst_sample_a", out_a, 0);
    check("rst_valid_a", vout_a, 0);
    check("rst_gate_a", gate_a, 0);
    check("rst_sample_b", out_b, 0);
    check("rst_valid_b", vout_b, 0);
    check("rst_gate_b", gate_b, 0);
    rst = 1'b0;
  endtask

  task automatic collect(input bit sel_b, input int n, input int budget);
    int waited = 0;
    cap_val.delete(); cap_gate.delete(); cap_cyc.delete();
    while (cap_val.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
      if (sel_b ? vout_b : vout_a) begin
        cap_val.push_back(sel_b ? out_b : out_a);
        cap_gate.push_back(sel_b ? gate_b : gate_a);
        cap_cyc.push_back(cyc);
      end
    end
    check("collect_count", cap_val.size(), n);
  endtask

  always @(negedge clk) begin
    if (vout_a) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_sample", out_a, ea.val);
        check("a_gate", gate_a, ea.gate);
        check("a_latency", cyc - ea.cyc, 3);
      end
    end
    if (vout_b) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_sample", out_b, eb.val);
        check("b_gate", gate_b, eb.gate);
        check("b_latency", cyc - eb.cyc, 3);
      end
    end
  end

  logic [23:0] sat_in  [3] = '{24'h400000, 24'hC00000, 24'h000100};
  logic [3:0]  sat_g   [3] = '{4'd1, 4'd2, 4'd8};
  logic [15:0] sat_exp [3] = '{16'h7FFF, 16'h8000, 16'h0100};
  logic [23:0] gt_in   [7] = '{24'h0, 24'h020000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h001000};
  // The DC tracker leaves a -2/-1 residue after the 0x020000 step, so the open gate passes -1.
  logic [15:0] gt_exp  [7] = '{16'h0, 16'h0200, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0};
  logic        gt_gate [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int seen;
    int bad;
    rst = 1'b1; vin = 1'b0; sample = '0; gain = '0; thr = '0;
    do_reset(2);

    // Latency and passthrough.
    fork
      begin drive(1, 24'h123400); drive(0, 0); end
      collect(0, 1, 10);
    join
    if (cap_val.size() == 1) begin
      check("pass_value", cap_val[0], 16'h1234);
      check("pass_gate", cap_gate[0], 1);
    end
    @(negedge clk);
    check("pass_single_pulse", vout_a, 0);

    // Saturation, each as the first sample after reset.
    for (int i = 0; i < 3; i++) begin
      do_reset(1);
      gain = sat_g[i];
      fork
        begin drive(1, sat_in[i]); drive(0, 0); end
        collect(0, 1, 10);
      join
      if (cap_val.size() == 1) check($sformatf("sat_%0d", i), cap_val[0], sat_exp[i]);
    end

    // Mid-stream reset with two samples in flight.
    gain = 0;
    drive(1, 24'h300000);
    drive(1, 24'h310000);
    do_reset(2);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (vout_a || vout_b) seen++;
    end
    check("no_stale_valid", seen, 0);

    // Gate open/hold/close.
    do_reset(1);
    thr = 16'h0100;
    fork
      begin
        for (int i = 0; i < 7; i++) drive(1, gt_in[i]);
        drive(0, 0);
      end
      collect(0, 7, 20);
    join
    if (cap_val.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("gate_out_%0d", i), cap_val[i], gt_exp[i]);
        check($sformatf("gate_state_%0d", i), cap_gate[i], gt_gate[i]);
      end
    end

    // DC removal on the DC_SHIFT=4 instance.
    do_reset(1);
    thr = 0;
    fork
      begin
        repeat (400) drive(1, 24'h010000);
        drive(0, 0);
      end
      collect(1, 400, 420);
    join
    if (cap_val.size() == 400) begin
      check("dc_first", cap_val[0], 16'h0100);
      bad = 0;
      for (int i = 1; i < 400; i++)
        if ($signed(cap_val[i]) > $signed(cap_val[i-1]) || cap_val[i][15]) bad++;
      check("dc_monotonic_violations", bad, 0);
      bad = 0;
      for (int i = 350; i < 400; i++) if (cap_val[i] != 16'h0) bad++;
      check("dc_tail_nonzero", bad, 0);
    end

    // Throughput: 64 back-to-back samples.
    do_reset(1);
    fork
      begin
        repeat (64) drive(1, 24'($urandom));
        drive(0, 0);
      end
      collect(0, 64, 80);
    join
    if (cap_cyc.size() == 64) begin
      bad = 0;
      for (int i = 1; i < 64; i++) if (cap_cyc[i] != cap_cyc[0] + i) bad++;
      check("throughput_gaps", bad, 0);
    end

    // Randomized bursts; gain/threshold only change while the pipeline is empty.
    do_reset(1);
    for (int b = 0; b < 40; b++) begin
      gain = 4'($urandom_range(0, 15));
      thr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      for (int k = 0; k < int'($urandom_range(1, 60)); k++) begin
        if ($urandom_range(0, 3) == 0) drive(0, 0);
        else if ($urandom_range(0, 1) == 0) drive(1, 24'($urandom));
        else drive(1, 24'(int'($urandom_range(0, 8191)) - 4096));
      end
      repeat (4) drive(0, 0);
    end

    repeat (6) @(negedge clk);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
